// File: rtl/idu_burst_pkg.sv
// idu_burst_pkg: shared op/state types for the burst increment/decrement unit
package idu_burst_pkg;
    typedef enum logic [2:0] {OP_PASS, OP_INC, OP_DEC, OP_ADJ, OP_BURST_INC, OP_BURST_DEC} idu2_op_t;
    typedef enum logic [1:0] {ST_IDLE, ST_SINGLE, ST_BURST} idu2_state_t;
    function automatic logic is_burst(idu2_op_t op);
        return op == OP_BURST_INC || op == OP_BURST_DEC;
    endfunction
endpackage

// File: rtl/idu_burst_step.sv
// idu_step: combinational pointer adder returning the modified value and a wrap flag
module idu_step
    import idu_burst_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OFF_W = 8
) (
    input  idu2_op_t           op,
    input  logic [OFF_W-1:0]   offset,
    input  logic [WIDTH-1:0]   value,
    output logic [WIDTH-1:0]   result,
    output logic               wrap
);
    logic [WIDTH+1:0] delta, sum;
    // two guard bits: a set bit means the true result left [0, 2^WIDTH)
    assign delta = op == OP_ADJ ? {{(WIDTH+2-OFF_W){offset[OFF_W-1]}}, offset}
                 : (op == OP_INC || op == OP_BURST_INC) ? (WIDTH+2)'(1)
                 : (op == OP_DEC || op == OP_BURST_DEC) ? '1 : '0;
    assign sum    = {2'b00, value} + delta;
    assign result = sum[WIDTH-1:0];
    assign wrap   = |sum[WIDTH+1:WIDTH];
endmodule

// File: rtl/idu_burst.sv
// idu_burst: pointer bank with post-modify single/burst address sequencing
module idu_burst
    import idu_burst_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int OFF_W   = 8,
    parameter int NUM_PTR = 4,
    parameter int LEN_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  idu2_op_t                   cmd_op,
    input  logic [$clog2(NUM_PTR)-1:0] cmd_ptr,
    input  logic [OFF_W-1:0]           cmd_offset,
    input  logic [LEN_W-1:0]           cmd_len,
    input  logic                       load_en,
    input  logic [$clog2(NUM_PTR)-1:0] load_ptr,
    input  logic [WIDTH-1:0]           load_data,
    output logic                       addr_valid,
    input  logic                       addr_ready,
    output logic [WIDTH-1:0]           addr,
    output logic                       addr_last,
    input  logic                       abort,
    input  logic [$clog2(NUM_PTR)-1:0] rd_sel,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       busy,
    output logic                       wrap,
    output logic                       load_err
);
    localparam int PW = $clog2(NUM_PTR);
    idu2_state_t state, state_nx;
    idu2_op_t op_q, step_op;
    logic [PW-1:0] ptr_q;
    logic [OFF_W-1:0] off_q, step_off;
    logic [LEN_W-1:0] cnt;
    logic [WIDTH-1:0] ptrs [NUM_PTR];
    logic [WIDTH-1:0] src, step_val, step_res;
    logic idle, accept, beat, load_ok, step_wrap;
    assign idle      = state == ST_IDLE;
    assign cmd_ready = idle && !abort;
    assign accept    = cmd_valid && cmd_ready;
    assign beat      = addr_valid && addr_ready;
    assign load_ok   = load_en && (idle || load_ptr != ptr_q);
    assign src       = (load_en && load_ptr == cmd_ptr) ? load_data : ptrs[cmd_ptr];
    assign rd_data   = ptrs[rd_sel];
    // accept only happens in IDLE and beats only outside it, so one adder serves both
    assign step_op  = idle ? cmd_op : op_q;
    assign step_off = idle ? cmd_offset : off_q;
    assign step_val = idle ? src : ptrs[ptr_q];
    idu_step #(.WIDTH(WIDTH), .OFF_W(OFF_W)) u_step (
        .op(step_op), .offset(step_off), .value(step_val), .result(step_res), .wrap(step_wrap)
    );
    always_comb begin
        state_nx = (abort && !idle) ? ST_IDLE
                 : accept ? (is_burst(cmd_op) ? ST_BURST : ST_SINGLE)
                 : (beat && (state == ST_SINGLE || cnt == '0)) ? ST_IDLE : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= OP_PASS;
            ptr_q      <= '0;
            off_q      <= '0;
            cnt        <= '0;
            addr_valid <= 1'b0;
            addr       <= '0;
            addr_last  <= 1'b0;
            busy       <= 1'b0;
            wrap       <= 1'b0;
            load_err   <= 1'b0;
            for (int i = 0; i < NUM_PTR; i++) ptrs[i] <= '0;
        end else begin
            state    <= state_nx;
            busy     <= state_nx != ST_IDLE;
            wrap     <= beat && step_wrap;
            load_err <= load_en && !load_ok;
            for (int i = 0; i < NUM_PTR; i++)
                if (load_ok && load_ptr == PW'(i)) ptrs[i] <= load_data;
                else if (beat && ptr_q == PW'(i)) ptrs[i] <= step_res;
            if (accept) begin
                op_q       <= cmd_op;
                ptr_q      <= cmd_ptr;
                off_q      <= cmd_offset;
                cnt        <= cmd_len;
                addr_valid <= 1'b1;
                addr       <= cmd_op == OP_ADJ ? step_res : src;
                addr_last  <= !is_burst(cmd_op) || cmd_len == '0;
            end else if (abort || beat) begin
                addr_valid <= state_nx == ST_BURST;
                addr_last  <= state_nx == ST_BURST && cnt == LEN_W'(1);
                if (state_nx == ST_BURST) begin
                    cnt  <= cnt - LEN_W'(1);
                    addr <= step_res;
                end
            end
        end
    end
endmodule

// File: tb/tb_idu_burst.sv
// tb_idu_burst: directed plus randomized checks of idu_burst against a beat-level model
module tb_idu_burst;
    import idu_burst_pkg::*;
    logic clk = 1'b0, rst;
    logic cmd_valid, cmd_ready, load_en, addr_valid, addr_ready, addr_last, abort, busy, wrap, load_err;
    idu2_op_t cmd_op;
    logic [1:0] cmd_ptr, load_ptr, rd_sel;
    logic [7:0] cmd_offset, cmd_len;
    logic [15:0] load_data, addr, rd_data;
    int checks = 0, errors = 0;
    int mp [4];
    bit m_act, m_wrap, m_lerr;
    idu2_op_t m_op;
    int m_idx, m_off, m_rem;

    idu_burst dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ptr(cmd_ptr), .cmd_offset(cmd_offset), .cmd_len(cmd_len), .load_en(load_en),
        .load_ptr(load_ptr), .load_data(load_data), .addr_valid(addr_valid), .addr_ready(addr_ready),
        .addr(addr), .addr_last(addr_last), .abort(abort), .rd_sel(rd_sel), .rd_data(rd_data),
        .busy(busy), .wrap(wrap), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_addr();
        return m_op == OP_ADJ ? (mp[m_idx] + m_off) & 'hFFFF : mp[m_idx];
    endfunction

    // called at a falling edge; returns at the next falling edge
    task automatic drive(input bit cv, input idu2_op_t op, input int p, input int off, input int len,
                         input bit le, input int lp, input int ld, input bit rdy, input bit ab);
        bit beat, lok, acc;
        int d, v;
        cmd_valid = cv; cmd_op = op; cmd_ptr = 2'(p); cmd_offset = 8'(off); cmd_len = 8'(len);
        load_en = le; load_ptr = 2'(lp); load_data = 16'(ld); addr_ready = rdy; abort = ab;
        rd_sel = 2'($urandom_range(3));
        #1;
        check("cmd_ready", cmd_ready, !m_act && !ab);
        check("rd_data", rd_data, mp[rd_sel]);
        beat = m_act && rdy;
        lok  = le && (!m_act || lp != m_idx);
        acc  = cv && !m_act && !ab;
        m_wrap = 0;
        if (beat) begin
            d = (m_op == OP_INC || m_op == OP_BURST_INC) ? 1
              : (m_op == OP_DEC || m_op == OP_BURST_DEC) ? -1
              : m_op == OP_ADJ ? m_off : 0;
            v = mp[m_idx] + d;
            m_wrap = v < 0 || v > 'hFFFF;
            mp[m_idx] = v & 'hFFFF;
            m_rem--;
            if (m_rem == 0) m_act = 0;
        end
        if (ab) m_act = 0;
        m_lerr = le && !lok;
        if (lok) mp[lp] = ld & 'hFFFF;
        if (acc) begin
            m_act = 1; m_op = op; m_idx = p;
            m_off = int'($signed(8'(off)));
            m_rem = (op == OP_BURST_INC || op == OP_BURST_DEC) ? len + 1 : 1;
        end
        @(posedge clk); #1;
        check("addr_valid", addr_valid, m_act);
        check("busy", busy, m_act);
        check("wrap", wrap, m_wrap);
        check("load_err", load_err, m_lerr);
        if (m_act) begin
            check("addr", addr, m_addr());
            check("addr_last", addr_last, m_rem == 1);
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        drive(0, OP_PASS, 0, 0, 0, 0, 0, 0, rdy, 0);
    endtask
    task automatic load(input int p, input int v);
        drive(0, OP_PASS, 0, 0, 0, 1, p, v, 0, 0);
    endtask
    task automatic cmd(input idu2_op_t op, input int p, input int off, input int len);
        drive(1, op, p, off, len, 0, 0, 0, 0, 0);
    endtask
    task automatic peek(input int sel, input int exp, input string tag);
        rd_sel = 2'(sel);
        #1;
        check(tag, rd_data, exp);
    endtask

    initial begin
        int n;
        int seen[$];
        int exp4[4] = '{'h0002, 'h0001, 'h0000, 'hFFFF};
        rst = 1; cmd_valid = 0; cmd_op = OP_PASS; cmd_ptr = 0; cmd_offset = 0; cmd_len = 0;
        load_en = 0; load_ptr = 0; load_data = 0; addr_ready = 0; abort = 0; rd_sel = 0;
        repeat (2) @(negedge clk);
        check("rst_valid", addr_valid, 0);
        check("rst_addr", addr, 0);
        check("rst_last", addr_last, 0);
        check("rst_busy", busy, 0);
        check("rst_wrap", wrap, 0);
        check("rst_lerr", load_err, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_rd", rd_data, 0);
        rst = 0;

        load(0, 'h00FF);
        cmd(OP_INC, 0, 0, 0);
        check("t1_addr", addr, 'h00FF);
        check("t1_last", addr_last, 1);
        idle(1);
        check("t1_wrap", wrap, 0);
        peek(0, 'h0100, "t1_ptr0");

        load(1, 'hFFFF);
        cmd(OP_BURST_INC, 1, 0, 2);
        check("t2_a0", addr, 'hFFFF);
        check("t2_l0", addr_last, 0);
        idle(1);
        check("t2_w1", wrap, 1);
        check("t2_a1", addr, 'h0000);
        idle(1);
        check("t2_w2", wrap, 0);
        check("t2_a2", addr, 'h0001);
        check("t2_l2", addr_last, 1);
        idle(1);
        check("t2_done", addr_valid, 0);
        peek(1, 'h0002, "t2_ptr1");

        load(2, 'h1000);
        cmd(OP_ADJ, 2, 'hFE, 0);
        check("t3_a0", addr, 'h0FFE);
        idle(1);
        peek(2, 'h0FFE, "t3_ptr2");
        cmd(OP_ADJ, 2, 'h7F, 0);
        check("t3_a1", addr, 'h107D);
        idle(1);

        load(3, 'h0002);
        cmd(OP_BURST_DEC, 3, 0, 3);
        for (int i = 0; i < 15; i++) begin
            if (!addr_valid) break;
            if (i % 3 == 0) seen.push_back(int'(addr));
            idle(i % 3 == 0);
        end
        check("t4_beats", seen.size(), 4);
        foreach (seen[k]) if (k < 4) check("t4_addr", seen[k], exp4[k]);

        load(0, 'h0010);
        cmd(OP_BURST_INC, 0, 0, 5);
        idle(1);
        drive(0, OP_PASS, 0, 0, 0, 0, 0, 0, 1, 1);
        check("t5_valid", addr_valid, 0);
        check("t5_busy", busy, 0);
        peek(0, 'h0012, "t5_ptr0");
        abort = 0;
        #1;
        check("t5_ready", cmd_ready, 1);

        load(1, 'h5555);
        cmd(OP_BURST_DEC, 1, 0, 3);
        drive(0, OP_PASS, 0, 0, 0, 1, 1, 'h1234, 0, 0);
        check("t6_lerr", load_err, 1);
        drive(0, OP_PASS, 0, 0, 0, 1, 2, 'hABCD, 0, 0);
        check("t6_lerr_off", load_err, 0);
        peek(1, 'h5555, "t6_ptr1");
        peek(2, 'hABCD, "t6_ptr2");
        for (int i = 0; i < 10 && m_act; i++) idle(1);

        drive(1, OP_INC, 0, 0, 0, 1, 0, 'h4444, 0, 0);
        check("t7_addr", addr, 'h4444);
        idle(1);
        peek(0, 'h4445, "t7_ptr0");

        load(3, 'h0100);
        cmd(OP_BURST_INC, 3, 0, 255);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (!addr_valid) break;
            idle(1);
            n++;
        end
        check("t8_beats", n, 256);
        peek(3, 'h0200, "t8_ptr3");

        for (int i = 0; i < 1500; i++) begin
            int sel, ld;
            sel = $urandom_range(2);
            ld = sel == 0 ? 0 : sel == 1 ? 'hFFFF : $urandom_range('hFFFF);
            drive($urandom_range(2) == 0, idu2_op_t'($urandom_range(5)), $urandom_range(3),
                  $urandom_range(255), $urandom_range(7) == 0 ? $urandom_range(40) : $urandom_range(3),
                  $urandom_range(3) == 0, $urandom_range(3), ld, $urandom_range(3) != 0,
                  m_act && $urandom_range(19) == 0);
        end
        for (int i = 0; i < 60 && m_act; i++) idle(1);

        load(2, 'h7777);
        cmd(OP_BURST_INC, 2, 0, 10);
        idle(1);
        #2 rst = 1;
        #1;
        check("t10_valid", addr_valid, 0);
        check("t10_busy", busy, 0);
        check("t10_addr", addr, 0);
        check("t10_last", addr_last, 0);
        peek(2, 0, "t10_ptr2");
        @(negedge clk);
        rst = 0;
        foreach (mp[k]) mp[k] = 0;
        m_act = 0;
        idle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/idu_burst.md
# idu_burst

Parametrised successor to the CPU's increment/decrement unit. It owns a small bank of pointer registers and runs post-modify address sequencing on them: single INC/DEC/PASS steps, signed relative adjust, and multi-beat INC/DEC bursts with a valid/ready address stream. It sits between the microcode sequencer (command side) and the bus arbiter (address side), and serves CPU block moves, HDMA and OAM DMA address generation.

## Interface
- `WIDTH`, 16: pointer and address width.
- `OFF_W`, 8: width of the signed relative offset.
- `NUM_PTR`, 4: number of pointer registers.
- `LEN_W`, 8: width of the burst length field.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_op` in `idu2_op_t`: one of PASS, INC, DEC, ADJ, BURST_INC, BURST_DEC.
- `cmd_ptr` in `$clog2(NUM_PTR)`: target pointer.
- `cmd_offset` in `OFF_W`: signed offset, used by ADJ only.
- `cmd_len` in `LEN_W`: burst beat count minus one.
- `load_en` in 1, `load_ptr` in `$clog2(NUM_PTR)`, `load_data` in `WIDTH`: direct pointer write.
- `addr_valid` out 1 / `addr_ready` in 1: address beat handshake.
- `addr` out `WIDTH`: beat address.
- `addr_last` out 1: marks the final beat of a command.
- `abort` in 1: terminates the active command.
- `rd_sel` in `$clog2(NUM_PTR)` / `rd_data` out `WIDTH`: combinational pointer read.
- `busy` out 1: high when state is not IDLE.
- `wrap` out 1: one-cycle pulse when a pointer update wraps.
- `load_err` out 1: one-cycle pulse when a load is dropped.

## Operation
- States:
  - IDLE: `cmd_ready` is 1.
  - SINGLE: one beat pending.
  - BURST: beats pending; beat counter `cnt` holds the remaining beats minus one.
- Command accept: `cmd_valid & cmd_ready`.
  - Latch op, pointer index, offset and `cnt` = `cmd_len`.
  - PASS, INC, DEC and ADJ go to SINGLE; BURST_* go to BURST.
- Beat address:
  - PASS, INC, DEC, BURST_*: the pointer value before update (post-modify).
  - ADJ: pointer + sign-extended offset (pre-modify).
- Pointer update on each accepted beat (`addr_valid & addr_ready`):
  - PASS: unchanged.
  - INC and BURST_INC: +1.
  - DEC and BURST_DEC: −1.
  - ADJ: + sign-extended offset.
  - All arithmetic is modulo 2^WIDTH.
- `wrap`: pulses on the update edge when INC goes from all-ones to 0, DEC goes from 0 to all-ones, or ADJ carries or borrows out of WIDTH bits.
- SINGLE: the accepted beat has `addr_last` = 1; the block then returns to IDLE.
- BURST: on each accepted beat, `cnt` decrements. `addr_last` = (`cnt` == 0). Accepting the last beat returns to IDLE.
- Burst length range: `cmd_len` = 0 gives 1 beat; all-ones gives 2^LEN_W beats.
- `abort`:
  - Forces IDLE on the next edge and drops `addr_valid`.
  - If a beat handshakes in the same cycle as `abort`, that beat's pointer update still commits.
- `load_en`:
  - Writes `load_ptr` when IDLE, or when `load_ptr` differs from the active pointer.
  - Otherwise the write is dropped and `load_err` pulses.
  - A load to a pointer that is also the target of a command accepted in the same cycle: the load wins, and the command starts from the loaded value.
- `rd_data`: reflects the register contents (post-edge values), with no bypass.
- Reset values:
  - All pointers 0, state IDLE, `cnt` 0.
  - `addr_valid` 0, `addr` 0, `addr_last` 0.
  - `wrap` 0, `load_err` 0, `busy` 0.

## Timing
- Command accepted at edge T: `addr_valid` = 1 and `addr` valid in the cycle after T.
- All outputs except `cmd_ready` and `rd_data` are registered.
- A beat is accepted at an edge with `addr_valid & addr_ready`. The next burst beat is presented in the following cycle with no bubble, giving 1 beat per cycle.
- While `addr_ready` = 0: `addr`, `addr_last` and the pointer are held stable.
- Last beat accepted at edge L: `cmd_ready` = 1 in the cycle after L. Next-command latency is 1 cycle.
- `rst` asserted mid-burst: immediate return to reset values, regardless of `clk`.

## Structure
- Shared CPU package gains `idu2_op_t`, a 3-bit enum with one value per op listed above.
- Sub-module `idu_step`: a combinational WIDTH-parametrised adder that takes op and offset and returns result and wrap. It generalises the existing IDU arithmetic.
- Top level holds the FSM, pointer bank, counter and handshake logic.

## Test plan
- Reset, load ptr0 = 0x00FF, then INC: one beat `addr` = 0x00FF with `addr_last` = 1; ptr0 = 0x0100; `wrap` = 0.
- ptr1 = 0xFFFF, BURST_INC with `cmd_len` = 2: beats 0xFFFF, 0x0000, 0x0001 on consecutive cycles. `wrap` pulses once, on the first beat. `addr_last` is on the third beat. ptr1 = 0x0002.
- ptr2 = 0x1000, ADJ with offset 0xFE: `addr` = 0x0FFE and ptr2 = 0x0FFE. Then ADJ with offset 0x7F: `addr` = 0x107D.
- BURST_DEC from 0x0002 with `cmd_len` = 3 and `addr_ready` toggling 1,0,0,1,…: `addr` held while not ready. Beats are 0x0002, 0x0001, 0x0000, 0xFFFF.
- Mid-burst `abort` together with a handshake: that beat's update commits, `addr_valid` = 0 next cycle, and `cmd_ready` = 1.
- Load to the active pointer while BURST: value unchanged, `load_err` = 1 for one cycle. Load to another pointer in the same cycle: written.
